// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: rebuilds x/y from an incoming active-low
// h_sync/v_sync pair, measures line and frame length, and reports lock.
module vga_sync_decoder #(
    parameter int H_TOTAL      = 800,
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 655,
    parameter int V_TOTAL      = 525,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 489
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        h_sync,
    input  logic        v_sync,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        h_display,
    output logic        v_display,
    output logic        locked,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines,
    output logic        sync_error
);

    localparam logic [9:0]  X_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  X_SYNC     = 10'(H_SYNC_START);
    localparam logic [9:0]  X_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0]  Y_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  Y_SYNC     = 10'(V_SYNC_START);
    localparam logic [9:0]  Y_ACT      = 10'(V_ACTIVE);
    localparam logic [10:0] P_NOM      = 11'(H_TOTAL);
    localparam logic [9:0]  LC_NOM     = 10'(V_TOTAL);
    localparam logic [10:0] P_PRE_SAT  = 11'd2046;
    localparam logic [9:0]  LC_PRE_SAT = 10'd1022;

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic [1:0] sat_match(input logic [1:0] c);
        return (c == 2'd2) ? c : c + 2'd1;
    endfunction

    logic        s_h, s_v, s_h_d, s_v_d;
    logic        h_edge, v_edge;
    logic [10:0] p;
    logic [9:0]  lc;
    logic        h_seen, v_seen;
    logic        h_locked, v_locked;
    logic [1:0]  match_cnt;
    logic        h_match, h_mismatch, h_timeout;
    logic        v_mismatch, v_timeout;

    assign h_edge = s_h_d & ~s_h;
    assign v_edge = s_v_d & ~s_v;

    assign h_match    = h_edge & h_seen & (p == P_NOM);
    assign h_mismatch = h_edge & h_seen & (p != P_NOM);
    // Timeout fires on the single increment into saturation, so it pulses once.
    assign h_timeout  = ~h_edge & (p == P_PRE_SAT);
    assign v_mismatch = v_edge & v_seen & (lc != LC_NOM);
    assign v_timeout  = ~v_edge & h_edge & (lc == LC_PRE_SAT);

    assign locked    = h_locked & v_locked;
    assign h_display = locked & (x < X_ACT);
    assign v_display = locked & (y < Y_ACT);

    always_ff @(posedge clk) begin
        if (reset) begin
            s_h         <= 1'b1;
            s_v         <= 1'b1;
            s_h_d       <= 1'b1;
            s_v_d       <= 1'b1;
            x           <= '0;
            y           <= '0;
            p           <= '0;
            lc          <= '0;
            h_seen      <= 1'b0;
            v_seen      <= 1'b0;
            h_locked    <= 1'b0;
            v_locked    <= 1'b0;
            match_cnt   <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            sync_error  <= 1'b0;
        end else begin
            s_h   <= h_sync;
            s_v   <= v_sync;
            s_h_d <= s_h;
            s_v_d <= s_v;

            if (h_edge)
                x <= X_SYNC;
            else if (x == X_LAST)
                x <= '0;
            else
                x <= x + 10'd1;

            // A v_edge realigns y even when it lands on the x wrap.
            if (v_edge)
                y <= Y_SYNC;
            else if (x == X_LAST)
                y <= (y == Y_LAST) ? '0 : y + 10'd1;

            if (h_edge) begin
                if (h_seen)
                    line_len <= p;
                p      <= 11'd1;
                h_seen <= 1'b1;
                if (h_match) begin
                    match_cnt <= sat_match(match_cnt);
                    h_locked  <= h_locked | (match_cnt != 2'd0);
                end else if (h_mismatch) begin
                    match_cnt <= '0;
                    h_locked  <= 1'b0;
                end
            end else begin
                p <= sat_inc11(p);
                if (h_timeout) begin
                    h_seen    <= 1'b0;
                    h_locked  <= 1'b0;
                    match_cnt <= '0;
                end
            end

            if (v_edge) begin
                if (v_seen) begin
                    frame_lines <= lc;
                    v_locked    <= (lc == LC_NOM);
                end
                lc     <= h_edge ? 10'd1 : 10'd0;
                v_seen <= 1'b1;
            end else if (h_edge) begin
                lc <= sat_inc10(lc);
                if (v_timeout) begin
                    v_seen   <= 1'b0;
                    v_locked <= 1'b0;
                end
            end

            sync_error <= h_mismatch | h_timeout | v_mismatch | v_timeout;
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a small-mode VGA generator drives the decoder,
// a queue scoreboard tracks expected position, and a phase table checks measurements.
module tb_vga_sync_decoder;

    localparam int HT  = 40;
    localparam int HA  = 32;
    localparam int HSS = 34;
    localparam int HSW = 4;
    localparam int VT  = 20;
    localparam int VA  = 16;
    localparam int VSS = 17;
    localparam int VSW = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        h_sync = 1'b1;
    logic        v_sync = 1'b1;
    logic [9:0]  x, y;
    logic        h_display, v_display, locked;
    logic [10:0] line_len;
    logic [9:0]  frame_lines;
    logic        sync_error;

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS)
    ) dut (
        .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync),
        .x(x), .y(y), .h_display(h_display), .v_display(v_display),
        .locked(locked), .line_len(line_len), .frame_lines(frame_lines),
        .sync_error(sync_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int gx;
        int gy;
        bit chk;
    } exp_t;

    typedef struct {
        int lines;
        int hlen;
        int vt;
        bit steady;
        int exp_len;
        int exp_frames;
        bit exp_locked;
        int exp_errs;
    } phase_t;

    exp_t   q[$];
    phase_t tbl[10];

    int n_checks = 0;
    int n_pass   = 0;
    int err_cnt  = 0;
    int gx = 0, gy = 0;
    int cur_hlen = HT, cur_vt = VT;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_pos(input exp_t e);
        bit ehd, evd;
        ehd = (e.gx < HA);
        evd = (e.gy < VA);
        n_checks++;
        if (int'(x) == e.gx && int'(y) == e.gy && h_display == ehd && v_display == evd
            && locked && !sync_error)
            n_pass++;
        else
            $display("FAIL pos(%0d,%0d): got x=%0d y=%0d hd=%0b vd=%0b lk=%0b err=%0b, expected x=%0d y=%0d hd=%0b vd=%0b lk=1 err=0",
                     e.gx, e.gy, x, y, h_display, v_display, locked, sync_error,
                     e.gx, e.gy, ehd, evd);
    endtask

    // One pixel clock: drive generator outputs (or idle-high), score the cycle
    // whose position the decoder is now showing, then advance the generator.
    task automatic step(input bit adv, input bit chk);
        exp_t e;
        if (adv) begin
            h_sync = !(gx >= HSS && gx < HSS + HSW);
            v_sync = !(gy >= VSS && gy < VSS + VSW);
        end else begin
            h_sync = 1'b1;
            v_sync = 1'b1;
        end
        q.push_back('{gx, gy, chk && adv});
        @(posedge clk);
        #1;
        if (sync_error) err_cnt++;
        if (q.size() > 1) begin
            e = q.pop_front();
            if (e.chk) check_pos(e);
        end
        if (adv) begin
            if (gx == cur_hlen - 1) begin
                gx = 0;
                gy = (gy == cur_vt - 1) ? 0 : gy + 1;
            end else begin
                gx++;
            end
        end
    endtask

    task automatic run_lines(input int n, input int hlen, input int vt, input bit steady);
        cur_hlen = hlen;
        cur_vt   = vt;
        for (int l = 0; l < n; l++)
            for (int c = 0; c < hlen; c++)
                step(1'b1, steady);
    endtask

    initial begin
        // nominal lock, steady, short line, recovery, wrong frame, recovery
        tbl[0] = '{40, HT,     VT,     1'b0, 40, 20, 1'b1, 0};
        tbl[1] = '{40, HT,     VT,     1'b1, 40, 20, 1'b1, 0};
        tbl[2] = '{1,  HT - 1, VT,     1'b0, 40, 20, 1'b1, 0};
        tbl[3] = '{1,  HT,     VT,     1'b0, 39, 20, 1'b0, 1};
        tbl[4] = '{2,  HT,     VT,     1'b0, 40, 20, 1'b1, 0};
        tbl[5] = '{16, HT,     VT,     1'b1, 40, 20, 1'b1, 0};
        tbl[6] = '{19, HT,     VT - 1, 1'b0, 40, 20, 1'b1, 0};
        tbl[7] = '{20, HT,     VT,     1'b0, 40, 19, 1'b0, 1};
        tbl[8] = '{20, HT,     VT,     1'b0, 40, 20, 1'b1, 0};
        tbl[9] = '{20, HT,     VT,     1'b1, 40, 20, 1'b1, 0};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_line_len", int'(line_len), 0);
        check("rst_frame_lines", int'(frame_lines), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_h_display", int'(h_display), 0);
        check("rst_v_display", int'(v_display), 0);
        check("rst_sync_error", int'(sync_error), 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            err_cnt = 0;
            run_lines(tbl[i].lines, tbl[i].hlen, tbl[i].vt, tbl[i].steady);
            check($sformatf("ph%0d_line_len", i), int'(line_len), tbl[i].exp_len);
            check($sformatf("ph%0d_frame_lines", i), int'(frame_lines), tbl[i].exp_frames);
            check($sformatf("ph%0d_locked", i), int'(locked), int'(tbl[i].exp_locked));
            check($sformatf("ph%0d_sync_errors", i), err_cnt, tbl[i].exp_errs);
        end

        // Sync loss: inputs idle high long enough for the period counter to saturate.
        err_cnt = 0;
        repeat (2100) step(1'b0, 1'b0);
        check("loss_sync_errors", err_cnt, 1);
        check("loss_locked", int'(locked), 0);
        check("loss_line_len", int'(line_len), 40);
        err_cnt = 0;
        run_lines(1, HT, VT, 1'b0);
        check("loss_first_edge_unmeasured", int'(line_len), 40);
        check("loss_first_edge_errors", err_cnt, 0);

        // Reset mid-line, then inputs idle high: counters restart with no false edge.
        repeat (20) step(1'b1, 1'b0);
        q.delete();
        err_cnt = 0;
        reset  = 1'b1;
        h_sync = 1'b1;
        v_sync = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_x", int'(x), 0);
        check("midrst_y", int'(y), 0);
        check("midrst_line_len", int'(line_len), 0);
        check("midrst_frame_lines", int'(frame_lines), 0);
        check("midrst_locked", int'(locked), 0);
        check("midrst_sync_error", int'(sync_error), 0);
        repeat (10) step(1'b0, 1'b0);
        check("midrst_idle_x", int'(x), 10);
        check("midrst_idle_y", int'(y), 0);
        check("midrst_idle_errors", err_cnt, 0);

        // Re-lock from scratch after reset.
        q.delete();
        gx = 0;
        gy = 0;
        err_cnt = 0;
        run_lines(2 * VT, HT, VT, 1'b0);
        check("relock_locked", int'(locked), 1);
        check("relock_line_len", int'(line_len), 40);
        check("relock_frame_lines", int'(frame_lines), 20);
        check("relock_errors", err_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing generator: it observes an incoming active-low `h_sync`/`v_sync` pair and recovers the pixel coordinates and display enables. It measures line length (clocks) and frame length (lines), and declares lock once the measured timing matches the configured mode. It sits on the capture/loopback path so that downstream logic can check a generated or external VGA stream pixel-by-pixel.

## Interface
- `H_TOTAL`, 800: clocks per line.
- `H_ACTIVE`, 640: active pixels per line.
- `H_SYNC_START`, 655: x position of the first sync-low pixel.
- `V_TOTAL`, 525: lines per frame.
- `V_ACTIVE`, 480: active lines per frame.
- `V_SYNC_START`, 489: y position of the first sync-low line.

Ports:
- `clk` input 1: pixel clock; one input sample per cycle.
- `reset` input 1: synchronous, active-high.
- `h_sync` input 1: horizontal sync, active low.
- `v_sync` input 1: vertical sync, active low.
- `x` output 10: recovered horizontal position.
- `y` output 10: recovered vertical position.
- `h_display` output 1: high when `locked` and `x < H_ACTIVE`.
- `v_display` output 1: high when `locked` and `y < V_ACTIVE`.
- `locked` output 1: `h_locked & v_locked`.
- `line_len` output 11: last measured clocks between `h_sync` falling edges.
- `frame_lines` output 10: last measured `h_sync` falling edges between `v_sync` falling edges.
- `sync_error` output 1: one-cycle pulse on mismatch or timeout.

## Operation
- **Input stage:**
  - `h_sync`/`v_sync` are registered into `s_h`/`s_v`, then delayed again into `s_h_d`/`s_v_d`.
  - `h_edge = s_h_d & ~s_h`; `v_edge = s_v_d & ~s_v`.
- **x counter:**
  - On `h_edge`: x <= H_SYNC_START.
  - Else if x == H_TOTAL-1: x <= 0.
  - Else: x <= x+1.
- **y counter:**
  - On `v_edge`: y <= V_SYNC_START (`v_edge` has priority over the wrap increment in the same cycle).
  - Else on an x wrap (x == H_TOTAL-1): y <= y+1, or y <= 0 when y == V_TOTAL-1.
- **Line measurement (period counter `p`, 11 bit, saturating at 2047):**
  - On `h_edge`: if `h_seen`, line_len <= p; then p <= 1 and h_seen <= 1.
  - Otherwise: p <= p+1, saturating at 2047.
- **Horizontal lock:**
  - On `h_edge` with `h_seen` and p == H_TOTAL: increment the match count (saturates at 2); `h_locked` is set when the count reaches 2.
  - On `h_edge` with `h_seen` and p != H_TOTAL: clear `h_locked` and the match count, and pulse `sync_error`.
  - Timeout: when `p` reaches 2047, clear `h_seen`, `h_locked` and the match count, and pulse `sync_error` once.
- **Frame measurement (line counter `lc`, 10 bit, saturating at 1023):**
  - `lc` increments on `h_edge`.
  - On `v_edge`: if `v_seen`, frame_lines <= lc; then lc <= 0, or lc <= 1 if `h_edge` occurs in the same cycle. Set `v_seen`.
- **Vertical lock:**
  - On `v_edge` with `v_seen`: `v_locked` <= (lc == V_TOTAL); a mismatch pulses `sync_error`.
  - Timeout: when `lc` reaches 1023, clear `v_seen`/`v_locked` and pulse `sync_error` once.
- Simultaneous horizontal and vertical errors produce a single `sync_error` pulse.

## Timing
- **Reset values:**
  - Outputs: x=0, y=0, line_len=0, frame_lines=0; `locked`, `h_display`, `v_display`, `sync_error` all 0.
  - Internal state: s_h=s_v=s_h_d=s_v_d=1 (idle high, so no false edge after reset), p=0, lc=0, h_seen=v_seen=0.
- **Reset mid-frame:** returns all state to the reset values on the next edge. Re-lock then needs 2 lines + 1 frame after the first edges.
- **Latency:** 2 cycles from input to position. An input sync-low sample presented in cycle t gives x == H_SYNC_START in cycle t+2.
- **Enables:** `h_display`, `v_display` and `locked` are combinational from the registered x, y and lock flags.
- **Lock timing (locked source):**
  - `h_locked` rises 2 cycles after the 3rd `h_sync` falling edge.
  - `v_locked` rises 2 cycles after the 2nd `v_sync` falling edge.
- **`sync_error`:** asserted in the cycle after the offending edge, or after saturation; exactly one cycle wide.

## Test plan
1. **Nominal lock:** drive default 800×525 timing (h sync low at positions 655–750, v sync low at lines 489–490) → line_len=800, frame_lines=525, `locked`=1 after frame 2; x=0,y=0 coincide with the generator's (0,0) delayed by 2 cycles.
2. **Enable windows:** in a locked steady state, `h_display`=1 for x 0–639 and 0 for 640–799; `v_display`=0 for y 480–524.
3. **Short line:** one line of 799 clocks → line_len=799, `sync_error` pulses once, `locked` drops, and recovers after 2 good lines.
4. **Sync loss:** hold `h_sync` high for 2100 cycles → single `sync_error` at p=2047, `locked`=0, and the next edge is not measured (`h_seen` cleared).
5. **Wrong frame:** a frame of 524 lines → frame_lines=524, `v_locked`=0, one `sync_error`; the next 525-line frame restores lock.
6. **Reset mid-line:** assert `reset` for 1 cycle at x=300 → all outputs at reset values the next cycle, and no spurious edge while inputs stay high.
